snoop_responder: RTL and testbench

Snoop side of one cache controller in the 3-CPU MSI snooping system. Consumes bus transactions issued by the other processors' request side. Looks up the addressed line, downgrades or invalidates it, and for Modified hits supplies the dirty block on the data bus while aborting the memory response. One instance per processor; sits between the machine/data bus arbiters and that processor's line array.

---
 rtl/snoop_responder.sv | 179 +++++++++++++++++
 tb/tb_snoop_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/snoop_responder.sv
// snoop_responder: snoop side of one MSI cache controller.
// Watches bus transactions issued by the other processors, looks up the
// addressed line, invalidates or downgrades it, and for Modified hits
// supplies the dirty block on the data bus while aborting the memory reply.
// Optional build macro SNOOP_STATS_EN adds saturating hit/flush counters.
module snoop_responder #(
  parameter logic [1:0] CPU_ID = 2'd0,
  parameter int         ADDR_W = 5,
  parameter int         DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              snoop_valid,
  output logic              snoop_ready,
  input  logic [1:0]        snoop_src,
  input  logic [1:0]        snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic [1:0]        snoop_block,
  output logic [1:0]        line_idx,
  input  logic [1:0]        line_state,
  input  logic [ADDR_W-1:0] line_tag,
  input  logic [DATA_W-1:0] line_data,
  output logic              state_we,
  output logic [1:0]        state_wdata,
  output logic              flush_valid,
  output logic [ADDR_W-1:0] flush_addr,
  output logic [DATA_W-1:0] flush_data,
  input  logic              flush_ack,
  output logic              abort_mem,
`ifdef SNOOP_STATS_EN
  output logic [15:0]       hit_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic              proto_err
);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_RD    = 2'd1;
  localparam logic [1:0] CMD_INV   = 2'd3;

  localparam logic [1:0] LINE_I = 2'd0;
  localparam logic [1:0] LINE_S = 2'd1;
  localparam logic [1:0] LINE_M = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FLUSH  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_block;
  logic [DATA_W-1:0] r_flushData;
  logic [1:0]        r_newState;
  logic              r_protoErr;

  logic w_accept;
  logic w_hit;
  logic w_hitM;

  // A transaction is only worth looking up if another CPU issued a real command
  assign w_accept = snoop_valid && (r_state == IDLE) &&
                    (snoop_src != CPU_ID) && (snoop_cmd != CMD_NONE);

  // Encoding 3 of line_state counts as Invalid, so only S and M can hit
  assign w_hit  = ((line_state == LINE_S) || (line_state == LINE_M)) &&
                  (line_tag == r_addr);
  assign w_hitM = w_hit && (line_state == LINE_M);

  // State register; async reset abandons any flush or pending write at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!w_hit) begin
          w_nextState = IDLE;
        end else if (w_hitM) begin
          w_nextState = (r_cmd == CMD_INV) ? UPDATE : FLUSH;
        end else begin
          w_nextState = (r_cmd == CMD_RD) ? IDLE : UPDATE;
        end
      end
      FLUSH: begin
        if (flush_ack) begin
          w_nextState = UPDATE;
        end
      end
      UPDATE: begin
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Transaction capture, flush data latch, target line state and sticky error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cmd       <= CMD_NONE;
      r_addr      <= '0;
      r_block     <= 2'd0;
      r_flushData <= '0;
      r_newState  <= LINE_I;
      r_protoErr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmd   <= snoop_cmd;
        r_addr  <= snoop_addr;
        r_block <= snoop_block;
      end
      if ((r_state == LOOKUP) && w_hit) begin
        if (w_hitM && (r_cmd != CMD_INV)) begin
          r_flushData <= line_data;
          r_newState  <= (r_cmd == CMD_RD) ? LINE_S : LINE_I;
        end else begin
          r_newState <= LINE_I;
        end
        if (w_hitM && (r_cmd == CMD_INV)) begin
          r_protoErr <= 1'b1;
        end
      end
    end
  end

  // Outputs decoded from the current state and the latched transaction
  always_comb begin
    snoop_ready = (r_state == IDLE);
    line_idx    = r_block;
    state_we    = (r_state == UPDATE);
    state_wdata = (r_state == UPDATE) ? r_newState : LINE_I;
    flush_valid = (r_state == FLUSH);
    abort_mem   = (r_state == FLUSH);
    flush_addr  = (r_state == FLUSH) ? r_addr : '0;
    flush_data  = (r_state == FLUSH) ? r_flushData : '0;
    proto_err   = r_protoErr;
  end

`ifdef SNOOP_STATS_EN
  logic [15:0] r_hitCnt;
  logic [15:0] r_flushCnt;

  // Saturating counters of lookup hits and accepted flushes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hitCnt   <= 16'd0;
      r_flushCnt <= 16'd0;
    end else begin
      if ((r_state == LOOKUP) && w_hit && (r_hitCnt != 16'hFFFF)) begin
        r_hitCnt <= r_hitCnt + 16'd1;
      end
      if ((r_state == FLUSH) && flush_ack && (r_flushCnt != 16'hFFFF)) begin
        r_flushCnt <= r_flushCnt + 16'd1;
      end
    end
  end

  assign hit_cnt   = r_hitCnt;
  assign flush_cnt = r_flushCnt;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: directed self-checking bench for snoop_responder
// with CPU_ID = 0. Each task drives one scenario and checks cycle by cycle.
module tb_snoop_responder;

   logic       clock = 1'b0;
   logic       reset;
   logic       snoopValid;
   logic       snoopReady;
   logic [1:0] snoopSrc;
   logic [1:0] snoopCmd;
   logic [4:0] snoopAddr;
   logic [1:0] snoopBlock;
   logic [1:0] lineIdx;
   logic [1:0] lineState;
   logic [4:0] lineTag;
   logic [7:0] lineData;
   logic       stateWe;
   logic [1:0] stateWdata;
   logic       flushValid;
   logic [4:0] flushAddr;
   logic [7:0] flushData;
   logic       flushAck;
   logic       abortMem;
   logic       protoErr;
`ifdef SNOOP_STATS_EN
   logic [15:0] hitCnt;
   logic [15:0] flushCnt;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   snoop_responder #(.CPU_ID(2'd0), .ADDR_W(5), .DATA_W(8)) dut (
      .clock(clock), .reset(reset),
      .snoop_valid(snoopValid), .snoop_ready(snoopReady),
      .snoop_src(snoopSrc), .snoop_cmd(snoopCmd),
      .snoop_addr(snoopAddr), .snoop_block(snoopBlock),
      .line_idx(lineIdx), .line_state(lineState),
      .line_tag(lineTag), .line_data(lineData),
      .state_we(stateWe), .state_wdata(stateWdata),
      .flush_valid(flushValid), .flush_addr(flushAddr),
      .flush_data(flushData), .flush_ack(flushAck),
      .abort_mem(abortMem),
`ifdef SNOOP_STATS_EN
      .hit_cnt(hitCnt), .flush_cnt(flushCnt),
`endif
      .proto_err(protoErr)
   );

   // Free-running clock, rising edge active
   always #5 clock = ~clock;

   // Presents one transaction for exactly one edge; returns 1 time unit into cycle 1
   task automatic applyStimulus(input logic [1:0] src, input logic [1:0] cmd,
                                input logic [4:0] addr, input logic [1:0] blk);
      snoopValid = 1'b1;
      snoopSrc   = src;
      snoopCmd   = cmd;
      snoopAddr  = addr;
      snoopBlock = blk;
      @(posedge clock); #1;
      snoopValid = 1'b0;
      snoopCmd   = 2'd0;
   endtask

   task automatic nextCycle();
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b want 1", snoopReady); end
      testsRun++; if (stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_we: got %b want 0", stateWe); end
      testsRun++; if (flushValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_flush: got %b want 0", flushValid); end
      testsRun++; if (abortMem !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_abort: got %b want 0", abortMem); end
      testsRun++; if (protoErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_proto: got %b want 0", protoErr); end
      testsRun++; if (lineIdx !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_idx: got %0d want 0", lineIdx); end
      reset = 1'b0;
      nextCycle();
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_release_ready: got %b want 1", snoopReady); end
   endtask

   // Own-CPU and NONE transactions must be swallowed even when the line would hit
   task automatic test_ignored();
      lineState = 2'd2; lineTag = 5'd8; lineData = 8'h77;
      applyStimulus(2'd0, 2'd1, 5'd8, 2'd0);
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL own_ready: got %b want 1", snoopReady); end
      nextCycle();
      testsRun++; if (flushValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL own_flush: got %b want 0", flushValid); end
      testsRun++; if (stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL own_we: got %b want 0", stateWe); end
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL own_ready2: got %b want 1", snoopReady); end
      applyStimulus(2'd1, 2'd0, 5'd8, 2'd0);
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL none_ready: got %b want 1", snoopReady); end
      nextCycle();
      testsRun++; if (flushValid !== 1'b0 || stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL none_action: got flush=%b we=%b want 0 0", flushValid, stateWe); end
   endtask

   task automatic test_shared_write_miss();
      lineState = 2'd1; lineTag = 5'd12; lineData = 8'h11;
      applyStimulus(2'd1, 2'd2, 5'd12, 2'd1);
      testsRun++; if (snoopReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL swr_c1_ready: got %b want 0", snoopReady); end
      testsRun++; if (lineIdx !== 2'd1) begin testsFailed++; $display("[TB] FAIL swr_c1_idx: got %0d want 1", lineIdx); end
      testsRun++; if (stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL swr_c1_we: got %b want 0", stateWe); end
      nextCycle();
      testsRun++; if (stateWe !== 1'b1) begin testsFailed++; $display("[TB] FAIL swr_c2_we: got %b want 1", stateWe); end
      testsRun++; if (stateWdata !== 2'd0) begin testsFailed++; $display("[TB] FAIL swr_c2_wdata: got %0d want 0", stateWdata); end
      testsRun++; if (lineIdx !== 2'd1) begin testsFailed++; $display("[TB] FAIL swr_c2_idx: got %0d want 1", lineIdx); end
      testsRun++; if (flushValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL swr_c2_flush: got %b want 0", flushValid); end
      nextCycle();
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL swr_c3_ready: got %b want 1", snoopReady); end
      testsRun++; if (stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL swr_c3_we: got %b want 0", stateWe); end
   endtask

   task automatic test_shared_read_hit();
      lineState = 2'd1; lineTag = 5'd6;
      applyStimulus(2'd2, 2'd1, 5'd6, 2'd2);
      testsRun++; if (stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL srd_c1_we: got %b want 0", stateWe); end
      nextCycle();
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL srd_c2_ready: got %b want 1", snoopReady); end
      testsRun++; if (stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL srd_c2_we: got %b want 0", stateWe); end
   endtask

   task automatic test_modified_flush();
      lineState = 2'd2; lineTag = 5'd8; lineData = 8'hA5;
      applyStimulus(2'd2, 2'd1, 5'd8, 2'd0);
      testsRun++; if (abortMem !== 1'b0) begin testsFailed++; $display("[TB] FAIL mfl_c1_abort: got %b want 0", abortMem); end
      testsRun++; if (flushValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mfl_c1_flush: got %b want 0", flushValid); end
      nextCycle();
      lineData = 8'h00;
      for (int c = 2; c <= 4; c++) begin
         testsRun++; if (flushValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL mfl_c%0d_flush: got %b want 1", c, flushValid); end
         testsRun++; if (abortMem !== 1'b1) begin testsFailed++; $display("[TB] FAIL mfl_c%0d_abort: got %b want 1", c, abortMem); end
         testsRun++; if (flushAddr !== 5'd8) begin testsFailed++; $display("[TB] FAIL mfl_c%0d_addr: got %0d want 8", c, flushAddr); end
         testsRun++; if (flushData !== 8'hA5) begin testsFailed++; $display("[TB] FAIL mfl_c%0d_data: got %h want a5", c, flushData); end
         testsRun++; if (stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL mfl_c%0d_we: got %b want 0", c, stateWe); end
         if (c == 4) flushAck = 1'b1;
         nextCycle();
      end
      flushAck = 1'b0;
      testsRun++; if (stateWe !== 1'b1) begin testsFailed++; $display("[TB] FAIL mfl_upd_we: got %b want 1", stateWe); end
      testsRun++; if (stateWdata !== 2'd1) begin testsFailed++; $display("[TB] FAIL mfl_upd_wdata: got %0d want 1", stateWdata); end
      testsRun++; if (abortMem !== 1'b0) begin testsFailed++; $display("[TB] FAIL mfl_upd_abort: got %b want 0", abortMem); end
      testsRun++; if (flushValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mfl_upd_flush: got %b want 0", flushValid); end
      nextCycle();
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL mfl_end_ready: got %b want 1", snoopReady); end
   endtask

   // Tag mismatch and the reserved state encoding must both behave as a miss
   task automatic test_miss();
      lineState = 2'd2; lineTag = 5'd8;
      applyStimulus(2'd1, 2'd1, 5'd10, 2'd0);
      testsRun++; if (snoopReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL miss_c1_ready: got %b want 0", snoopReady); end
      nextCycle();
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL miss_c2_ready: got %b want 1", snoopReady); end
      testsRun++; if (flushValid !== 1'b0 || stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL miss_c2_action: got flush=%b we=%b want 0 0", flushValid, stateWe); end
      lineState = 2'd3; lineTag = 5'd10;
      applyStimulus(2'd1, 2'd2, 5'd10, 2'd0);
      nextCycle();
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL st3_c2_ready: got %b want 1", snoopReady); end
      testsRun++; if (flushValid !== 1'b0 || stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL st3_c2_action: got flush=%b we=%b want 0 0", flushValid, stateWe); end
   endtask

   task automatic test_invalidate_modified();
      lineState = 2'd2; lineTag = 5'd14; lineData = 8'h5A;
      applyStimulus(2'd1, 2'd3, 5'd14, 2'd2);
      testsRun++; if (protoErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL inv_c1_proto: got %b want 0", protoErr); end
      nextCycle();
      testsRun++; if (protoErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL inv_c2_proto: got %b want 1", protoErr); end
      testsRun++; if (stateWe !== 1'b1) begin testsFailed++; $display("[TB] FAIL inv_c2_we: got %b want 1", stateWe); end
      testsRun++; if (stateWdata !== 2'd0) begin testsFailed++; $display("[TB] FAIL inv_c2_wdata: got %0d want 0", stateWdata); end
      testsRun++; if (flushValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL inv_c2_flush: got %b want 0", flushValid); end
      nextCycle();
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL inv_c3_ready: got %b want 1", snoopReady); end
      testsRun++; if (protoErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL inv_c3_sticky: got %b want 1", protoErr); end
   endtask

   task automatic test_reset_mid_flush();
      lineState = 2'd2; lineTag = 5'd20; lineData = 8'h3C;
      applyStimulus(2'd1, 2'd2, 5'd20, 2'd3);
      nextCycle();
      testsRun++; if (flushValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rmf_pre_flush: got %b want 1", flushValid); end
      #2;
      reset = 1'b1;
      #1;
      testsRun++; if (flushValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmf_async_flush: got %b want 0", flushValid); end
      testsRun++; if (abortMem !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmf_async_abort: got %b want 0", abortMem); end
      testsRun++; if (stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmf_async_we: got %b want 0", stateWe); end
      testsRun++; if (protoErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmf_async_proto: got %b want 0", protoErr); end
      @(posedge clock); #1;
      flushAck = 1'b1;
      reset = 1'b0;
      nextCycle();
      testsRun++; if (stateWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmf_post_we: got %b want 0", stateWe); end
      testsRun++; if (snoopReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL rmf_post_ready: got %b want 1", snoopReady); end
      flushAck = 1'b0;
      nextCycle();
      testsRun++; if (stateWe !== 1'b0 || flushValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmf_post2: got we=%b flush=%b want 0 0", stateWe, flushValid); end
   endtask

   // Scenario sequence followed by the summary line
   initial begin
      reset = 1'b1; snoopValid = 1'b0; snoopSrc = 2'd0; snoopCmd = 2'd0;
      snoopAddr = 5'd0; snoopBlock = 2'd0; lineState = 2'd0; lineTag = 5'd0;
      lineData = 8'd0; flushAck = 1'b0;
      test_reset();
      test_ignored();
      test_shared_write_miss();
      test_shared_read_hit();
      test_modified_flush();
      test_miss();
      test_invalidate_modified();
      test_reset_mid_flush();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
